regfile_wb_queue: RTL and testbench

- Writer-side companion to the 16x16 three-port register file: owns the single write port (we3/wa3/wd3).
- Accepts results from two producers (ALU, load unit) over valid/ready handshakes and buffers them in an in-order FIFO.
- Drains at most one entry per cycle into the register file.
- Provides two lookup ports so operand-read logic can detect and forward pending writes.

---
 rtl/regfile_wb_queue.sv | 147 ++++++++++++++
 tb/tb_regfile_wb_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue in front of the register file's single write port.
// Optional lookup/forwarding of pending writes is enabled by defining WB_FORWARD_EN.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_addr,
  input  logic [DW-1:0]            alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [AW-1:0]            ld_addr,
  input  logic [DW-1:0]            ld_data,
  input  logic                     wb_en,
  input  logic                     flush,
  output logic                     we3,
  output logic [AW-1:0]            wa3,
  output logic [DW-1:0]            wd3,
  input  logic [AW-1:0]            la1,
  input  logic [AW-1:0]            la2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [DW-1:0]            fwd1,
  output logic [DW-1:0]            fwd2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] addr_r [DEPTH];
  logic [DW-1:0] data_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;

  logic          space_s;
  logic          ld_fire_s;
  logic          alu_fire_s;
  logic          push_s;
  logic          pop_s;
  logic [AW-1:0] push_addr_s;
  logic [DW-1:0] push_data_s;

  assign count     = count_r;
  assign empty     = (count_r == {CW{1'b0}});
  assign we3       = ~empty;
  // Space comes from registered occupancy only, so a same-cycle drain never frees a slot.
  assign space_s   = (count_r < DEPTH_C);
  assign ld_ready  = space_s & ~flush;
  assign alu_ready = space_s & ~flush & ~ld_valid;
  assign ld_fire_s  = ld_valid & ld_ready;
  assign alu_fire_s = alu_valid & alu_ready;
  assign pop_s      = we3 & wb_en;

  // Select the accepted producer and drop writes to r0.
  always_comb begin
    push_addr_s = alu_addr;
    push_data_s = alu_data;
    if (ld_valid) begin
      push_addr_s = ld_addr;
      push_data_s = ld_data;
    end else begin
      push_addr_s = alu_addr;
      push_data_s = alu_data;
    end
    push_s = (ld_fire_s | alu_fire_s) & (push_addr_s != {AW{1'b0}});
  end

  // Queue storage, pointers and occupancy; flush outranks push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= {AW{1'b0}};
        data_r[i] <= {DW{1'b0}};
      end
    end else if (flush) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        addr_r[tail_r] <= push_addr_s;
        data_r[tail_r] <= push_data_s;
        tail_r         <= tail_r + PW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry drives the write port; zeros when nothing is pending.
  always_comb begin
    wa3 = {AW{1'b0}};
    wd3 = {DW{1'b0}};
    if (empty) begin
      wa3 = {AW{1'b0}};
      wd3 = {DW{1'b0}};
    end else begin
      wa3 = addr_r[head_r];
      wd3 = data_r[head_r];
    end
  end

`ifdef WB_FORWARD_EN
  // Walk oldest to youngest so the last match is the youngest pending value.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] la);
    logic [DW:0]   res;
    logic [PW-1:0] idx;
    res = {(DW+1){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_r + PW'(k);
      res = ((CW'(k) < count_r) && (addr_r[idx] == la)) ? {1'b1, data_r[idx]} : res;
    end
    return (la == {AW{1'b0}}) ? {(DW+1){1'b0}} : res;
  endfunction

  // Combinational search of the queued entries for both lookup ports.
  always_comb begin
    {hit1, fwd1} = lookup(la1);
    {hit2, fwd2} = lookup(la2);
  end
`else
  logic unused_lookup_s;
  assign unused_lookup_s = ^{la1, la2};
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
  assign fwd1 = {DW{1'b0}};
  assign fwd2 = {DW{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed scenarios plus a randomized
// run against a queue-based reference model of the write-back behaviour.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 4;
  localparam int DW    = 16;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, alu_valid, ld_valid, wb_en, flush;
  logic [AW-1:0] alu_addr, ld_addr, la1, la2;
  logic [DW-1:0] alu_data, ld_data;
  logic          alu_ready, ld_ready, we3, hit1, hit2, empty;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3, fwd1, fwd2;
  logic [$clog2(DEPTH):0] count;

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .wb_en(wb_en), .flush(flush),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .la1(la1), .la2(la2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
    .count(count), .empty(empty)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];
  bit   ld_acc, alu_acc;
  int   checks = 0;
  int   failures = 0;

  // Reference model: pending writes in acceptance order.
  task automatic tick();
    bit space, ldr, alr;
    @(posedge clk);
    space   = (mq.size() < DEPTH);
    ldr     = space && !flush;
    alr     = ldr && !ld_valid;
    ld_acc  = 1'b0;
    alu_acc = 1'b0;
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      ld_acc  = ld_valid && ldr;
      alu_acc = alu_valid && alr;
      if (mq.size() > 0 && wb_en) void'(mq.pop_front());
      if (ld_acc && ld_addr != 4'd0) mq.push_back({ld_addr, ld_data});
      else if (alu_acc && alu_addr != 4'd0) mq.push_back({alu_addr, alu_data});
    end
    #1;
  endtask

  function automatic logic [DW:0] model_lookup(input logic [AW-1:0] la);
    if (!FWD || la == 4'd0) return 17'd0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == la) return {1'b1, mq[i].d};
    return 17'd0;
  endfunction

  task automatic idle_inputs();
    alu_valid = 1'b0; ld_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
    alu_addr = 4'd0; alu_data = 16'd0; ld_addr = 4'd0; ld_data = 16'd0;
    la1 = 4'd0; la2 = 4'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks += 7;
    if (we3 !== 1'b0)      begin failures++; $display("FAIL reset_we3 got=%b exp=0", we3); end
    if (wa3 !== 4'd0)      begin failures++; $display("FAIL reset_wa3 got=%h exp=0", wa3); end
    if (wd3 !== 16'd0)     begin failures++; $display("FAIL reset_wd3 got=%h exp=0", wd3); end
    if (empty !== 1'b1)    begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    if (count !== 3'd0)    begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    if (alu_ready !== 1'b1) begin failures++; $display("FAIL reset_alu_ready got=%b exp=1", alu_ready); end
    if (hit1 !== 1'b0 || fwd1 !== 16'd0) begin failures++; $display("FAIL reset_hit1 got=%b/%h exp=0/0", hit1, fwd1); end
  endtask

  task automatic test_alu_push();
    wb_en = 1'b1; alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'h1234;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin failures++; $display("FAIL alu_push_ready got=%b exp=1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    checks += 3;
    if (we3 !== 1'b1)      begin failures++; $display("FAIL alu_push_we3 got=%b exp=1", we3); end
    if (wa3 !== 4'd3)      begin failures++; $display("FAIL alu_push_wa3 got=%h exp=3", wa3); end
    if (wd3 !== 16'h1234)  begin failures++; $display("FAIL alu_push_wd3 got=%h exp=1234", wd3); end
    tick();
    checks++;
    if (empty !== 1'b1)    begin failures++; $display("FAIL alu_push_drained got=%b exp=1", empty); end
  endtask

  task automatic test_priority();
    wb_en = 1'b0;
    ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 16'hAAAA;
    alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 16'h5555;
    #1;
    checks += 2;
    if (ld_ready !== 1'b1)  begin failures++; $display("FAIL prio_ld_ready got=%b exp=1", ld_ready); end
    if (alu_ready !== 1'b0) begin failures++; $display("FAIL prio_alu_blocked got=%b exp=0", alu_ready); end
    tick();
    ld_valid = 1'b0;
    #1;
    checks += 2;
    if (count !== 3'd1)     begin failures++; $display("FAIL prio_count1 got=%0d exp=1", count); end
    if (alu_ready !== 1'b1) begin failures++; $display("FAIL prio_alu_ready got=%b exp=1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd2)     begin failures++; $display("FAIL prio_count2 got=%0d exp=2", count); end
    wb_en = 1'b1;
    #1;
    checks += 2;
    if (we3 !== 1'b1 || wa3 !== 4'd5) begin failures++; $display("FAIL prio_first_addr got=%b/%h exp=1/5", we3, wa3); end
    if (wd3 !== 16'hAAAA)   begin failures++; $display("FAIL prio_first_data got=%h exp=aaaa", wd3); end
    tick();
    checks += 2;
    if (we3 !== 1'b1 || wa3 !== 4'd6) begin failures++; $display("FAIL prio_second_addr got=%b/%h exp=1/6", we3, wa3); end
    if (wd3 !== 16'h5555)   begin failures++; $display("FAIL prio_second_data got=%h exp=5555", wd3); end
    tick();
    checks++;
    if (empty !== 1'b1)     begin failures++; $display("FAIL prio_drained got=%b exp=1", empty); end
  endtask

  task automatic test_full();
    wb_en = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      alu_valid = 1'b1; alu_addr = 4'(i); alu_data = 16'(16'h0100 + i);
      tick();
    end
    alu_addr = 4'd7; alu_data = 16'h0777;
    #1;
    checks += 3;
    if (count !== 3'd4)     begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
    if (alu_ready !== 1'b0) begin failures++; $display("FAIL full_alu_ready got=%b exp=0", alu_ready); end
    if (ld_ready !== 1'b0)  begin failures++; $display("FAIL full_ld_ready got=%b exp=0", ld_ready); end
    wb_en = 1'b1;
    #1;
    checks++;
    if (alu_ready !== 1'b0) begin failures++; $display("FAIL full_drain_not_free got=%b exp=0", alu_ready); end
    tick();
    checks += 2;
    if (count !== 3'd3)     begin failures++; $display("FAIL full_count3 got=%0d exp=3", count); end
    if (alu_ready !== 1'b1) begin failures++; $display("FAIL full_reopen got=%b exp=1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    checks += 2;
    if (count !== 3'd3)     begin failures++; $display("FAIL full_pushpop_count got=%0d exp=3", count); end
    if (wa3 !== 4'd3)       begin failures++; $display("FAIL full_order got=%h exp=3", wa3); end
    for (int i = 0; i < 10 && empty !== 1'b1; i++) tick();
    checks++;
    if (empty !== 1'b1)     begin failures++; $display("FAIL full_drain_timeout got=%b exp=1", empty); end
  endtask

  task automatic test_r0();
    wb_en = 1'b1; alu_valid = 1'b1; alu_addr = 4'd0; alu_data = 16'hFFFF;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin failures++; $display("FAIL r0_ready got=%b exp=1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0)     begin failures++; $display("FAIL r0_count got=%0d exp=0", count); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (we3 !== 1'b0)     begin failures++; $display("FAIL r0_we3 cyc=%0d got=%b exp=0", i, we3); end
      tick();
    end
  endtask

  task automatic test_forward();
    logic [DW:0] exp1;
    wb_en = 1'b0; la1 = 4'd2; la2 = 4'd0;
    alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 16'h0001;
    tick();
    alu_data = 16'h0002;
    tick();
    alu_valid = 1'b0;
    #1;
    exp1 = FWD ? {1'b1, 16'h0002} : 17'd0;
    checks += 3;
    if ({hit1, fwd1} !== exp1) begin failures++; $display("FAIL fwd_youngest got=%b/%h exp=%b/%h", hit1, fwd1, exp1[16], exp1[15:0]); end
    if (hit2 !== 1'b0 || fwd2 !== 16'd0) begin failures++; $display("FAIL fwd_r0 got=%b/%h exp=0/0", hit2, fwd2); end
    if (count !== 3'd2)     begin failures++; $display("FAIL fwd_count got=%0d exp=2", count); end
    flush = 1'b1; ld_valid = 1'b1; ld_addr = 4'd9; ld_data = 16'h0009;
    #1;
    checks++;
    if (ld_ready !== 1'b0)  begin failures++; $display("FAIL flush_ready got=%b exp=0", ld_ready); end
    tick();
    flush = 1'b0; ld_valid = 1'b0;
    #1;
    checks += 2;
    if (hit1 !== 1'b0)      begin failures++; $display("FAIL flush_hit1 got=%b exp=0", hit1); end
    if (count !== 3'd0)     begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
  endtask

  task automatic test_random();
    logic [DW:0] e1, e2;
    bit exp_ldr, exp_alr, exp_we;
    ent_t head;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst_n = ($urandom_range(99) >= 2);
      flush = ($urandom_range(99) < 4);
      wb_en = ($urandom_range(99) < 65);
      if (!ld_valid || ld_acc) begin
        ld_valid = ($urandom_range(99) < 40);
        ld_addr  = 4'($urandom_range(4));
        ld_data  = 16'($urandom);
      end
      if (!alu_valid || alu_acc) begin
        alu_valid = ($urandom_range(99) < 60);
        alu_addr  = 4'($urandom_range(4));
        alu_data  = 16'($urandom);
      end
      la1 = 4'($urandom_range(4));
      la2 = 4'($urandom_range(4));
      #1;
      exp_ldr = (mq.size() < DEPTH) && !flush;
      exp_alr = exp_ldr && !ld_valid;
      exp_we  = (mq.size() > 0);
      head    = exp_we ? mq[0] : '0;
      e1 = model_lookup(la1);
      e2 = model_lookup(la2);
      checks += 7;
      if (ld_ready !== exp_ldr)  begin failures++; $display("FAIL rnd_ld_ready cyc=%0d got=%b exp=%b", cyc, ld_ready, exp_ldr); end
      if (alu_ready !== exp_alr) begin failures++; $display("FAIL rnd_alu_ready cyc=%0d got=%b exp=%b", cyc, alu_ready, exp_alr); end
      if (we3 !== exp_we)        begin failures++; $display("FAIL rnd_we3 cyc=%0d got=%b exp=%b", cyc, we3, exp_we); end
      if ({wa3, wd3} !== {head.a, head.d}) begin failures++; $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", cyc, wa3, wd3, head.a, head.d); end
      if (count !== 3'(mq.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count, mq.size()); end
      if ({hit1, fwd1} !== e1)   begin failures++; $display("FAIL rnd_lookup1 cyc=%0d la=%0d got=%b/%h exp=%b/%h", cyc, la1, hit1, fwd1, e1[16], e1[15:0]); end
      if ({hit2, fwd2} !== e2)   begin failures++; $display("FAIL rnd_lookup2 cyc=%0d la=%0d got=%b/%h exp=%b/%h", cyc, la2, hit2, fwd2, e2[16], e2[15:0]); end
      tick();
    end
  endtask

  initial begin
    ld_acc = 1'b0; alu_acc = 1'b0;
    test_reset();
    test_alu_push();
    test_priority();
    test_full();
    test_r0();
    test_forward();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
